// File: rtl/mriscv_axil_wb_bridge_if.sv
// AXI4-Lite responder channels plus processorci core-bus signals of the bridge.
// slave = bridge view, master = CPU/bus-environment view.
interface mriscv_axil_wb_bridge_if;
    logic        AWvalid;
    logic        AWready;
    logic [31:0] AWdata;
    logic [2:0]  AWprot;
    logic        Wvalid;
    logic        Wready;
    logic [31:0] Wdata;
    logic [3:0]  Wstrb;
    logic        Bvalid;
    logic        Bready;
    logic        ARvalid;
    logic        ARready;
    logic [31:0] ARdata;
    logic [2:0]  ARprot;
    logic        Rvalid;
    logic        RReady;
    logic [31:0] Rdata;
    logic        core_cyc;
    logic        core_stb;
    logic        core_we;
    logic [3:0]  core_wstrb;
    logic [31:0] core_addr;
    logic [31:0] core_data_out;
    logic [31:0] core_data_in;
    logic        core_ack;
    logic        bus_err;

    modport slave (
        input  AWvalid, AWdata, AWprot, Wvalid, Wdata, Wstrb, Bready,
               ARvalid, ARdata, ARprot, RReady, core_data_in, core_ack,
        output AWready, Wready, Bvalid, ARready, Rvalid, Rdata,
               core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out, bus_err
    );

    modport master (
        output AWvalid, AWdata, AWprot, Wvalid, Wdata, Wstrb, Bready,
               ARvalid, ARdata, ARprot, RReady, core_data_in, core_ack,
        input  AWready, Wready, Bvalid, ARready, Rvalid, Rdata,
               core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out, bus_err
    );
endinterface

// File: rtl/mriscv_axil_wb_bridge.sv
// AXI4-Lite to processorci core-bus bridge: one transaction at a time, ack timeout.
// Latency: handshake -> response >= 2 cycles; backpressure: no AW/W/AR accepted until B/R handshakes.
module mriscv_axil_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
    parameter bit          WRITE_PRIORITY = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mriscv_axil_wb_bridge_if.slave        bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WCOLLECT, BUS_WR, WRESP, BUS_RD, RRESP} state_t;

    state_t        state;
    logic          accept_en;
    logic          aw_got, w_got;
    logic          bvalid, rvalid, cyc, we, bus_err;
    logic [31:0]   rdata, addr, wdata;
    logic [3:0]    wstrb;
    logic [CW-1:0] to_cnt;
    logic          aw_rdy, w_rdy, ar_rdy;
    logic          aw_hs, w_hs, ar_hs, to_hit;
    logic          unused_bits;

    assign unused_bits = ^{bus.AWprot, bus.ARprot, bus.AWdata[1:0], bus.ARdata[1:0]};

    // accept_en keeps every ready low while in reset and during the first cycle after it
    always_comb begin
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        ar_rdy = 1'b0;
        if (accept_en && state == IDLE) begin
            if (WRITE_PRIORITY) begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                ar_rdy = !bus.AWvalid && !bus.Wvalid;
            end else begin
                ar_rdy = 1'b1;
                aw_rdy = !bus.ARvalid;
                w_rdy  = !bus.ARvalid;
            end
        end else if (state == WCOLLECT) begin
            aw_rdy = !aw_got;
            w_rdy  = !w_got;
        end
    end

    assign aw_hs  = bus.AWvalid && aw_rdy;
    assign w_hs   = bus.Wvalid && w_rdy;
    assign ar_hs  = bus.ARvalid && ar_rdy;
    assign to_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            accept_en <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            bvalid    <= 1'b0;
            rvalid    <= 1'b0;
            cyc       <= 1'b0;
            we        <= 1'b0;
            bus_err   <= 1'b0;
            rdata     <= '0;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            to_cnt    <= '0;
        end else begin
            accept_en <= 1'b1;
            bus_err   <= 1'b0;
            if (aw_hs) addr <= {bus.AWdata[31:2], 2'b00};
            if (w_hs) begin
                wdata <= bus.Wdata;
                wstrb <= bus.Wstrb;
            end
            case (state)
                IDLE: begin
                    if (aw_hs && w_hs) begin
                        state  <= BUS_WR;
                        cyc    <= 1'b1;
                        we     <= 1'b1;
                        to_cnt <= '0;
                    end else if (aw_hs || w_hs) begin
                        state  <= WCOLLECT;
                        aw_got <= aw_hs;
                        w_got  <= w_hs;
                    end else if (ar_hs) begin
                        state  <= BUS_RD;
                        addr   <= {bus.ARdata[31:2], 2'b00};
                        wstrb  <= 4'b0000;
                        we     <= 1'b0;
                        cyc    <= 1'b1;
                        to_cnt <= '0;
                    end
                end
                WCOLLECT: begin
                    if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                        state  <= BUS_WR;
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                        cyc    <= 1'b1;
                        we     <= 1'b1;
                        to_cnt <= '0;
                    end
                end
                BUS_WR, BUS_RD: begin
                    // an ack coinciding with the last timeout cycle counts as a normal completion
                    if (bus.core_ack || to_hit) begin
                        cyc     <= 1'b0;
                        bus_err <= !bus.core_ack;
                        if (state == BUS_RD) begin
                            rvalid <= 1'b1;
                            rdata  <= bus.core_ack ? bus.core_data_in : ERR_DATA;
                            state  <= RRESP;
                        end else begin
                            bvalid <= 1'b1;
                            state  <= WRESP;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WRESP: begin
                    if (bus.Bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RRESP: begin
                    if (bus.RReady) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.AWready       = aw_rdy;
    assign bus.Wready        = w_rdy;
    assign bus.ARready       = ar_rdy;
    assign bus.Bvalid        = bvalid;
    assign bus.Rvalid        = rvalid;
    assign bus.Rdata         = rdata;
    assign bus.core_cyc      = cyc;
    assign bus.core_stb      = cyc;
    assign bus.core_we       = we;
    assign bus.core_wstrb    = wstrb;
    assign bus.core_addr     = addr;
    assign bus.core_data_out = wdata;
    assign bus.bus_err       = bus_err;
endmodule

// File: tb/tb_mriscv_axil_wb_bridge.sv
// Directed bench: dut_a (timeout 8, write priority) covers most cases; dut_b (read priority) covers arbitration order.
module tb_mriscv_axil_wb_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mriscv_axil_wb_bridge_if a ();
    mriscv_axil_wb_bridge_if b ();

    mriscv_axil_wb_bridge #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF), .WRITE_PRIORITY(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    mriscv_axil_wb_bridge #(.TIMEOUT_CYCLES(256), .ERR_DATA(32'hDEAD_BEEF), .WRITE_PRIORITY(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // core-bus responder for dut_a: ack in the ack_delay-th cycle of cyc (0 = never)
    int          ack_delay = 0;
    logic [31:0] rd_data = '0;
    int          cyc_cnt = 0;
    int          bus_cycles = 0;
    int          unstable = 0;
    logic [31:0] snap_addr, snap_data;
    logic [3:0]  snap_strb;
    logic        snap_we;

    initial begin
        a.core_ack = 1'b0;
        a.core_data_in = '0;
        forever begin
            tick();
            if (a.core_cyc) begin
                cyc_cnt++;
                if (cyc_cnt == 1) begin
                    bus_cycles++;
                    snap_addr = a.core_addr;
                    snap_data = a.core_data_out;
                    snap_strb = a.core_wstrb;
                    snap_we   = a.core_we;
                end else if (a.core_addr !== snap_addr || a.core_we !== snap_we ||
                             a.core_wstrb !== snap_strb || (snap_we && a.core_data_out !== snap_data)) begin
                    unstable++;
                end
            end else begin
                cyc_cnt = 0;
            end
            a.core_ack = (ack_delay != 0) && a.core_cyc && (cyc_cnt == ack_delay);
            a.core_data_in = rd_data;
        end
    end

    // wait up to 30 cycles for Bvalid (which=0) or Rvalid (which=1) on dut_a
    task automatic wait_resp(input int which, output int n);
        n = 0;
        while (!((which == 0) ? a.Bvalid : a.Rvalid) && n < 30) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

    int n, b0;

    initial begin
        {a.AWvalid, a.Wvalid, a.ARvalid, a.Bready, a.RReady} = '0;
        a.AWdata = '0; a.AWprot = '0; a.Wdata = '0; a.Wstrb = '0; a.ARdata = '0; a.ARprot = '0;
        {b.AWvalid, b.Wvalid, b.ARvalid, b.Bready, b.RReady, b.core_ack} = '0;
        b.AWdata = '0; b.AWprot = '0; b.Wdata = '0; b.Wstrb = '0; b.ARdata = '0; b.ARprot = '0;
        b.core_data_in = '0;

        // reset state
        repeat (3) tick();
        chk("rst_awready", 32'(a.AWready), 0);
        chk("rst_arready", 32'(a.ARready), 0);
        chk("rst_cyc", 32'(a.core_cyc), 0);
        chk("rst_valids", 32'({a.Bvalid, a.Rvalid, a.bus_err}), 0);
        chk("rst_rdata", a.Rdata, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_readies", 32'({a.AWready, a.Wready, a.ARready}), 32'b111);

        // 1: aligned write, ack in third cyc cycle
        ack_delay = 3;
        a.AWvalid = 1; a.AWdata = 32'h100; a.Wvalid = 1; a.Wdata = 32'hA5A5_0F0F; a.Wstrb = 4'b0011;
        #1 chk("wr_arready_blocked", 32'(a.ARready), 0);
        tick();
        a.AWvalid = 0; a.Wvalid = 0;
        chk("wr_cyc_stb_we", 32'({a.core_cyc, a.core_stb, a.core_we}), 32'b111);
        chk("wr_addr", a.core_addr, 32'h100);
        chk("wr_strb", 32'(a.core_wstrb), 32'h3);
        chk("wr_data", a.core_data_out, 32'hA5A5_0F0F);
        chk("wr_busy_awready", 32'(a.AWready), 0);
        wait_resp(0, n);
        chk("wr_latency", 32'(n), 3);
        chk("wr_cyc_dropped", 32'(a.core_cyc), 0);
        chk("wr_hold", 32'(unstable), 0);
        a.Bready = 1;
        tick();
        a.Bready = 0;
        chk("wr_bvalid_clear", 32'(a.Bvalid), 0);

        // 2: read with unaligned address, ack in first cyc cycle, R held 5 cycles
        ack_delay = 1; rd_data = 32'h1234_5678;
        a.ARvalid = 1; a.ARdata = 32'h206;
        #1 chk("rd_arready", 32'(a.ARready), 1);
        tick();
        a.ARvalid = 0;
        chk("rd_addr", a.core_addr, 32'h204);
        chk("rd_we_strb", 32'({a.core_we, a.core_wstrb}), 0);
        tick();
        chk("rd_min_latency", 32'(a.Rvalid), 1);
        chk("rd_bvalid_excl", 32'(a.Bvalid), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_hold_valid", 32'(a.Rvalid), 1);
            chk("rd_hold_data", a.Rdata, 32'h1234_5678);
        end
        a.RReady = 1;
        tick();
        a.RReady = 0;
        chk("rd_rvalid_clear", 32'(a.Rvalid), 0);

        // 3: split write, W first, AW four cycles later
        ack_delay = 2; b0 = bus_cycles;
        a.Wvalid = 1; a.Wdata = 32'hCAFE_0001; a.Wstrb = 4'hF;
        tick();
        a.Wvalid = 0; a.Wdata = 32'h0BAD_0BAD; a.ARvalid = 1; a.ARdata = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1 chk("split_arready", 32'({a.ARready, a.Wready, a.AWready}), 32'b001);
            tick();
        end
        chk("split_no_cyc", 32'(a.core_cyc), 0);
        a.ARvalid = 0; a.AWvalid = 1; a.AWdata = 32'h10C;
        tick();
        a.AWvalid = 0;
        chk("split_addr", a.core_addr, 32'h10C);
        chk("split_data", a.core_data_out, 32'hCAFE_0001);
        wait_resp(0, n);
        chk("split_bvalid", 32'(a.Bvalid), 1);
        a.Bready = 1;
        tick();
        a.Bready = 0;
        chk("split_one_cycle", 32'(bus_cycles - b0), 1);

        // 4a: simultaneous AR+AW+W with write priority
        ack_delay = 1; rd_data = 32'h55AA_55AA;
        a.AWvalid = 1; a.AWdata = 32'h400; a.Wvalid = 1; a.Wdata = 32'h1111_2222; a.Wstrb = 4'hF;
        a.ARvalid = 1; a.ARdata = 32'h500;
        #1 chk("wp1_arready", 32'(a.ARready), 0);
        tick();
        a.AWvalid = 0; a.Wvalid = 0;
        chk("wp1_first_write", 32'({a.core_we, a.core_addr}), {1'b1, 32'h400});
        wait_resp(0, n);
        a.Bready = 1;
        tick();
        a.Bready = 0;
        chk("wp1_read_ready", 32'(a.ARready), 1);
        tick();
        a.ARvalid = 0;
        chk("wp1_then_read", 32'({a.core_we, a.core_addr}), {1'b0, 32'h500});
        wait_resp(1, n);
        chk("wp1_rdata", a.Rdata, 32'h55AA_55AA);
        a.RReady = 1;
        tick();
        a.RReady = 0;

        // 4b: same request on read-priority instance
        b.AWvalid = 1; b.AWdata = 32'h400; b.Wvalid = 1; b.Wdata = 32'h1111_2222; b.Wstrb = 4'hF;
        b.ARvalid = 1; b.ARdata = 32'h500;
        #1 chk("wp0_readies", 32'({b.AWready, b.Wready, b.ARready}), 32'b001);
        tick();
        b.ARvalid = 0;
        chk("wp0_first_read", 32'({b.core_cyc, b.core_we, b.core_addr}), {2'b10, 32'h500});
        b.core_ack = 1; b.core_data_in = 32'h77;
        tick();
        b.core_ack = 0;
        chk("wp0_rdata", 32'({b.Rvalid, b.Rdata}), {1'b1, 32'h77});
        chk("wp0_rresp_blocks", 32'(b.AWready), 0);
        b.RReady = 1;
        tick();
        b.RReady = 0;
        chk("wp0_idle_awready", 32'(b.AWready), 1);
        tick();
        b.AWvalid = 0; b.Wvalid = 0;
        chk("wp0_then_write", 32'({b.core_cyc, b.core_we, b.core_addr}), {2'b11, 32'h400});
        b.core_ack = 1;
        tick();
        b.core_ack = 0;
        chk("wp0_bvalid", 32'({b.Bvalid, b.Rvalid}), 32'b10);
        b.Bready = 1;
        tick();
        b.Bready = 0;

        // 5: timeout on a read, then ack in the last allowed cycle
        ack_delay = 0;
        a.ARvalid = 1; a.ARdata = 32'h600;
        tick();
        a.ARvalid = 0;
        n = 0;
        while (a.core_cyc && n < 20) begin
            tick();
            n++;
        end
        chk("to_cyc_len", 32'(n), 8);
        chk("to_bus_err", 32'(a.bus_err), 1);
        chk("to_rdata", 32'({a.Rvalid, a.Rdata}), {1'b1, 32'hDEAD_BEEF});
        tick();
        chk("to_err_pulse", 32'(a.bus_err), 0);
        a.RReady = 1;
        tick();
        a.RReady = 0;
        ack_delay = 8; rd_data = 32'h0BAD_F00D;
        a.ARvalid = 1; a.ARdata = 32'h604;
        tick();
        a.ARvalid = 0;
        n = 0;
        while (a.core_cyc && n < 20) begin
            tick();
            n++;
        end
        chk("late_ack_len", 32'(n), 8);
        chk("late_ack_no_err", 32'(a.bus_err), 0);
        chk("late_ack_rdata", 32'({a.Rvalid, a.Rdata}), {1'b1, 32'h0BAD_F00D});
        a.RReady = 1;
        tick();
        a.RReady = 0;

        // 6: reset in the middle of a bus write
        ack_delay = 0;
        a.AWvalid = 1; a.AWdata = 32'h800; a.Wvalid = 1; a.Wdata = 32'h1; a.Wstrb = 4'hF;
        tick();
        a.AWvalid = 0; a.Wvalid = 0;
        tick();
        chk("mid_wr_cyc", 32'(a.core_cyc), 1);
        #2 rst_n = 1'b0;
        #1 chk("arst_outputs", 32'({a.core_cyc, a.Bvalid, a.Rvalid, a.AWready}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        ack_delay = 1; rd_data = 32'h600D_CAFE;
        a.ARvalid = 1; a.ARdata = 32'h700;
        tick();
        a.ARvalid = 0;
        wait_resp(1, n);
        chk("post_rst_latency", 32'(n), 1);
        chk("post_rst_rdata", a.Rdata, 32'h600D_CAFE);
        chk("post_rst_no_b", 32'(a.Bvalid), 0);
        a.RReady = 1;
        tick();
        a.RReady = 0;
        chk("final_hold", 32'(unstable), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
